// File: rtl/mc_mem_responder.sv
// Unified instruction/data word memory for the multicycle CPU, answering level
// read/write strobes with a request/ready handshake after LATENCY (1..15) wait states.
//   state  | meaning
//   IDLE   | waiting for mem_read or mem_write
//   ACCESS | wait states counting down; array accessed when the counter reaches zero
//   DONE   | ready held with rdata/err until both requests drop
module mc_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_ILL} op_t;

    localparam int AW = DEPTH_LOG2 + 2;

    state_t              r_state;
    state_t              w_next_state;
    op_t                 r_op;
    logic [AW-1:0]       r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_cnt;
    logic [31:0]         r_mem [0:(1<<DEPTH_LOG2)-1];

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_req;
    logic                  w_legal;
    logic                  w_fire;
    logic                  w_mem_we;
    logic                  w_unused_addr;

    // Upper address bits are dropped so the byte space wraps at 2^AW.
    assign w_unused_addr = ^addr[31:AW];

    assign w_idx    = r_addr[AW-1:2];
    assign w_req    = mem_read | mem_write;
    assign w_legal  = (r_op != OP_ILL) && (r_addr[1:0] == 2'b00);
    assign w_fire   = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_mem_we = w_fire && w_legal && (r_op == OP_WR);
    assign busy     = (r_state != S_IDLE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_req) w_next_state = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_next_state = S_DONE;
            S_DONE:   if (!w_req) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= OP_RD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= 4'd0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr  <= addr[AW-1:0];
                        r_wdata <= wdata;
                        r_cnt   <= 4'(LATENCY - 1);
                        if (mem_read && mem_write) r_op <= OP_ILL;
                        else if (mem_write)        r_op <= OP_WR;
                        else                       r_op <= OP_RD;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        ready <= 1'b1;
                        err   <= ~w_legal;
                        if (w_legal && (r_op == OP_RD)) rdata <= r_mem[w_idx];
                    end
                end
                S_DONE: begin
                    if (!w_req) begin
                        ready <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array is not reset; a reset mid-ACCESS leaves r_state in IDLE so the write never fires.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_idx] <= r_wdata;
    end

endmodule

// File: doc/mc_mem_responder.md
Name: mc_mem_responder

Overview:
- Unified instruction/data word memory that serves the multicycle CPU's read and write strobes.
- Runs a 4-phase request/ready handshake with a configurable number of wait states, so the control FSM can stall in its fetch and memory states instead of assuming single-cycle memory.
- Sits between the datapath's address mux (PC or ALUOut) and the IR/MDR registers.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit words (256 words = 1 KiB).
- LATENCY, 2, wait states from request acceptance to ready. Legal range is 1..15.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  1  read request, level.
- mem_write  in  1  write request, level.
- addr  in  32  byte address. Must be word-aligned.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- ready  out  1  transaction complete. Held high until the request drops.
- busy  out  1  high when the FSM state is not IDLE.
- err  out  1  error flag. Valid while ready is high.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
  - On reset: state = IDLE, rdata = 0, ready = 0, err = 0, busy = 0, wait counter = 0.
  - Memory array contents are not reset.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If mem_read or mem_write is high at the rising edge, capture addr, wdata and op (rd/wr). Load the counter with LATENCY-1 and go to ACCESS.
  - If both requests are high, capture op = illegal.
- ACCESS:
  - Each edge with counter != 0: decrement the counter.
  - Edge with counter == 0, performed in that same edge:
    - Legal aligned read: rdata <= mem[addr[DEPTH_LOG2+1:2]], err <= 0.
    - Legal aligned write: mem[...] <= wdata, err <= 0, rdata unchanged.
    - Misaligned (addr[1:0] != 0) or illegal op: no array access, rdata unchanged, err <= 1.
    - Then ready <= 1 and go to DONE.
- DONE:
  - ready stays high and rdata/err are held.
  - On the first edge where mem_read = mem_write = 0: ready <= 0, err <= 0, go to IDLE.
- Latency: request first sampled at edge k gives ready visible after edge k+LATENCY. With LATENCY=2, ready is high 2 cycles after acceptance.
- Request changes are ignored in ACCESS and DONE. Address and data are the values captured at acceptance.
- Address bits above DEPTH_LOG2+1 are ignored, so the address space wraps modulo 2^(DEPTH_LOG2+2) bytes.
- A request re-asserted in the same cycle IDLE is re-entered is accepted at the next edge. Minimum back-to-back spacing is LATENCY+2 cycles.
- Reset during ACCESS discards the pending write (array unchanged) and drops to IDLE immediately. Reset during DONE clears ready at once.
- busy = (state != IDLE), combinational from the state register.
- Read-after-write to the same address returns the new data.

Test Plan:
- Reset, then read addr 0x0 with mem[0] preloaded to 0x8C010004 -> busy rises after edge 0, ready high after edge 2, rdata = 0x8C010004, err = 0; ready held until mem_read drops, then busy = 0 one edge later.
- Write 0xDEADBEEF to 0x10, release, then read 0x10 -> second transaction returns rdata = 0xDEADBEEF, err = 0.
- Read addr 0x402 (misaligned) -> ready after 2 cycles, err = 1, rdata keeps its previous value; err clears when the request drops.
- Assert mem_read and mem_write together at 0x20 with mem[8] = 0x1 -> err = 1, mem[8] still 0x1 afterwards.
- Write 0x55 to 0x8, assert rst one cycle after acceptance -> ready never rises, state is IDLE, and a subsequent read of 0x8 returns the old contents.
- LATENCY=1 build plus address wrap: write 0xA5A5 to 0x404, read 0x004 -> ready 1 cycle after acceptance, rdata = 0xA5A5.
